// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file / MAC accumulator block.
// These are used by regfile_acc and rf_scoreboard.
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int ACC_W = 64;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    // One-hot decode of a register address. x0 never appears in the mask.
    function automatic logic [NREGS-1:0] addr_onehot(input reg_addr_t addr, input logic en);
        logic [NREGS-1:0] mask;
        mask = '0;
        if (en && addr != REG_ZERO) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: one bit per register, raises stall on RAW hazards.
// The REGFILE_BYPASS_EN macro lets a same-cycle writeback hide its own pending bit.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_en_i,
    input  reg_addr_t issue_rd_i,
    input  logic      wr_en_i,
    input  reg_addr_t rd_addr_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    output logic      stall_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] eff_pending;

    assign set_mask = addr_onehot(issue_rd_i, issue_en_i);
    assign clr_mask = addr_onehot(rd_addr_i, wr_en_i);

    // Set after clear: a re-issued destination belongs to the newer writer.
    always_comb begin
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        eff_pending    = pending_q & ~(clr_mask & ~set_mask);
        eff_pending[0] = 1'b0;
    end
`else
    always_comb begin
        eff_pending    = pending_q;
        eff_pending[0] = 1'b0;
    end
`endif

    assign stall_o = eff_pending[rs1_addr_i] | eff_pending[rs2_addr_i];

endmodule

// File: rtl/regfile_acc.sv
// Architectural integer register file plus 64-bit MAC accumulator with RAW scoreboard.
// Defining REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_acc #(
    parameter int XLEN  = 32,
    parameter int ACC_W = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [XLEN-1:0]  write_data,
    input  logic             acc_wr_en,
    input  logic [ACC_W-1:0] accumul,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [ACC_W-1:0] acc_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             stall
);

    import rf_pkg::REG_ZERO;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             reg_we;

    assign reg_we = wr_en && (rd_addr != AW'(REG_ZERO));

    always_comb begin
        acc_d = acc_q;
        if (acc_wr_en) begin
            acc_d = accumul;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            acc_q <= '0;
        end else begin
            if (reg_we) begin
                regs_q[rd_addr] <= write_data;
            end
            acc_q <= acc_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != AW'(REG_ZERO)) begin
            rs1_data = (reg_we && rd_addr == rs1_addr) ? write_data : regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != AW'(REG_ZERO)) begin
            rs2_data = (reg_we && rd_addr == rs2_addr) ? write_data : regs_q[rs2_addr];
        end
    end
`else
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != AW'(REG_ZERO)) begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != AW'(REG_ZERO)) begin
            rs2_data = regs_q[rs2_addr];
        end
    end
`endif

    assign acc_data = acc_q;

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en_i (issue_en),
        .issue_rd_i (issue_rd),
        .wr_en_i    (wr_en),
        .rd_addr_i  (rd_addr),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .stall_o    (stall)
    );

endmodule
